// File: rtl/vram_arbiter.sv
// VRAM slot arbiter: one access per clk_sys cycle shared between video fetch,
// a 4-entry CPU write buffer and single-outstanding CPU reads.
module vram_arbiter (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic        vid_valid,
    output logic [7:0]  vid_data,
    input  logic        cpu_wr_req,
    input  logic [14:0] cpu_wr_addr,
    input  logic [7:0]  cpu_wr_data,
    output logic        cpu_wr_ready,
    input  logic        cpu_rd_req,
    input  logic [14:0] cpu_rd_addr,
    output logic        cpu_rd_ack,
    output logic [7:0]  cpu_rd_data,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout,
    output logic [2:0]  wbuf_level,
    output logic        wbuf_ovf,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VID    = 2'd1,
        ST_WDRAIN = 2'd2,
        ST_RD     = 2'd3
    } arb_state_t;

    // state_d is this cycle's grant; state_q remembers last cycle's grant and
    // doubles as the first stage of both return pipelines.
    arb_state_t state_q, state_d;

    logic [14:0] fifo_addr [4];
    logic [7:0]  fifo_data [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  level;
    logic [14:0] mem_addr_q;
    logic [7:0]  mem_din_q;
    logic        push, pop, rd_busy;

    // Write port handshake: a transfer happens only on cpu_wr_req && cpu_wr_ready;
    // a request while not ready is dropped and flagged in wbuf_ovf.
    assign cpu_wr_ready = (level < 3'd4);
    assign push         = cpu_wr_req && cpu_wr_ready;
    assign pop          = (state_d == ST_WDRAIN);
    assign rd_busy      = (state_q == ST_RD) || cpu_rd_ack;
    assign wbuf_level   = level;
    assign arb_state    = state_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // A read waits for an empty buffer and no same-cycle push so it never
    // overtakes an accepted write.
    always_comb begin
        state_d = ST_IDLE;
        if (vid_req)
            state_d = ST_VID;
        else if (level != 3'd0)
            state_d = ST_WDRAIN;
        else if (cpu_rd_req && !rd_busy && !push)
            state_d = ST_RD;
    end

    always_comb begin
        mem_addr = mem_addr_q;
        mem_din  = mem_din_q;
        mem_we   = 1'b0;
        case (state_d)
            ST_VID:    mem_addr = vid_addr;
            ST_WDRAIN: begin
                mem_addr = fifo_addr[rd_ptr];
                mem_din  = fifo_data[rd_ptr];
                mem_we   = 1'b1;
            end
            ST_RD:     mem_addr = cpu_rd_addr;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            mem_addr_q <= mem_addr;
            mem_din_q  <= mem_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wbuf_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
            if (cpu_wr_req && !cpu_wr_ready) wbuf_ovf <= 1'b1;
        end
    end

    // mem_dout during the cycle after a grant belongs to that grant.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vid_valid   <= 1'b0;
            vid_data    <= '0;
            cpu_rd_ack  <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            vid_valid  <= (state_q == ST_VID);
            cpu_rd_ack <= (state_q == ST_RD);
            if (state_q == ST_VID) vid_data    <= mem_dout;
            if (state_q == ST_RD)  cpu_rd_data <= mem_dout;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model.
module tb_vram_arbiter;

    logic        clk_sys;
    logic        reset;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        cpu_wr_req;
    logic [14:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ready;
    logic        cpu_rd_req;
    logic [14:0] cpu_rd_addr;
    logic        cpu_rd_ack;
    logic [7:0]  cpu_rd_data;
    logic [14:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic [2:0]  wbuf_level;
    logic        wbuf_ovf;
    logic [1:0]  arb_state;

    localparam logic [1:0] S_IDLE = 2'd0, S_VID = 2'd1, S_WDRAIN = 2'd2, S_RD = 2'd3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  vram [0:32767];
    logic [22:0] exp_q [$];
    logic [22:0] exp_w;

    vram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ack(cpu_rd_ack),
        .cpu_rd_data(cpu_rd_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .wbuf_level(wbuf_level), .wbuf_ovf(wbuf_ovf), .arb_state(arb_state)
    );

    // clock / reset
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // synchronous VRAM: data for an address appears the cycle after it is issued
    always @(posedge clk_sys) begin
        if (mem_we === 1'b1) vram[mem_addr] <= mem_din;
        mem_dout <= vram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_sys);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        vid_req     = 1'b0;
        cpu_wr_req  = 1'b0;
        cpu_rd_req  = 1'b0;
    endtask

    task automatic drive_wr(input logic [14:0] a, input logic [7:0] d);
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
    endtask

    task automatic drive_vid(input logic [14:0] a);
        vid_req  = 1'b1;
        vid_addr = a;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32768; i++) vram[i] = 8'h00;
        vram[15'h1800] = 8'hA5;
        vram[15'h2000] = 8'h77;
        vram[15'h0100] = 8'h99;
        vram[15'h0200] = 8'h11;
        drive_idle();
        vid_addr = '0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_rd_addr = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_vid_valid", vid_valid, 0);
        check_eq("rst_rd_ack", cpu_rd_ack, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_level", wbuf_level, 0);
        check_eq("rst_ovf", wbuf_ovf, 0);
        check_eq("rst_wr_ready", cpu_wr_ready, 1);
        check_eq("rst_vid_data", vid_data, 0);
        check_eq("rst_rd_data", cpu_rd_data, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_din", mem_din, 0);
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle(); settle();
        check_eq("idle_state", arb_state, S_IDLE);

        // video latency: grant same cycle, data two cycles later
        next_cycle(); drive_vid(15'h1800); settle();
        check_eq("vid_mem_addr", mem_addr, 15'h1800);
        check_eq("vid_mem_we", mem_we, 0);
        check_eq("vid_state", arb_state, S_VID);
        next_cycle(); vid_req = 1'b0; settle();
        check_eq("vid_valid_c11", vid_valid, 0);
        check_eq("idle_addr_hold", mem_addr, 15'h1800);
        next_cycle(); settle();
        check_eq("vid_valid_c12", vid_valid, 1);
        check_eq("vid_data_c12", vid_data, 8'hA5);
        next_cycle(); settle();
        check_eq("vid_valid_c13", vid_valid, 0);
        check_eq("vid_data_hold", vid_data, 8'hA5);

        // back-to-back video pulses
        next_cycle(); drive_vid(15'h1800);
        next_cycle(); drive_vid(15'h2000);
        next_cycle(); vid_req = 1'b0; settle();
        check_eq("b2b_valid0", vid_valid, 1);
        check_eq("b2b_data0", vid_data, 8'hA5);
        next_cycle(); settle();
        check_eq("b2b_valid1", vid_valid, 1);
        check_eq("b2b_data1", vid_data, 8'h77);
        next_cycle(); settle();
        check_eq("b2b_valid_end", vid_valid, 0);

        // fill buffer under continuous video, no drain possible
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_vid(15'h0300 + 15'(i));
            drive_wr(15'h4000 + 15'(i), 8'(i + 1));
            exp_q.push_back({15'h4000 + 15'(i), 8'(i + 1)});
            settle();
            check_eq("fill_no_we", mem_we, 0);
            check_eq("fill_ready", cpu_wr_ready, 1);
        end
        next_cycle(); drive_vid(15'h0310); drive_wr(15'h7FFF, 8'hEE); settle();
        check_eq("full_level", wbuf_level, 4);
        check_eq("full_ready", cpu_wr_ready, 0);
        check_eq("full_no_we", mem_we, 0);
        check_eq("full_ovf_pre", wbuf_ovf, 0);
        next_cycle(); drive_vid(15'h0311); cpu_wr_req = 1'b0; settle();
        check_eq("ovf_set", wbuf_ovf, 1);
        check_eq("ovf_level", wbuf_level, 4);
        check_eq("ovf_no_we", mem_we, 0);
        next_cycle(); vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            settle();
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 23'h0;
            check_eq("drain_we", mem_we, 1);
            check_eq("drain_state", arb_state, S_WDRAIN);
            check_eq("drain_addr", mem_addr, exp_w[22:8]);
            check_eq("drain_din", mem_din, exp_w[7:0]);
        end
        next_cycle(); settle();
        check_eq("drained_we", mem_we, 0);
        check_eq("drained_level", wbuf_level, 0);
        check_eq("drained_ready", cpu_wr_ready, 1);
        check_eq("drained_addr_hold", mem_addr, 15'h4003);
        check_eq("ovf_sticky", wbuf_ovf, 1);
        check_eq("ovf_not_written", vram[15'h7FFF], 8'h00);
        check_eq("vram_4002", vram[15'h4002], 8'h03);

        // read after write
        next_cycle(); drive_wr(15'h0100, 8'h3C); settle();
        check_eq("raw_no_bypass", mem_we, 0);
        next_cycle(); cpu_wr_req = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = 15'h0100; settle();
        check_eq("raw_drain_first", arb_state, S_WDRAIN);
        check_eq("raw_drain_addr", mem_addr, 15'h0100);
        check_eq("raw_drain_din", mem_din, 8'h3C);
        next_cycle(); settle();
        check_eq("raw_rd_grant", arb_state, S_RD);
        check_eq("raw_rd_addr", mem_addr, 15'h0100);
        check_eq("raw_rd_we", mem_we, 0);
        next_cycle(); settle();
        check_eq("raw_ack_early", cpu_rd_ack, 0);
        check_eq("raw_busy1", arb_state, S_IDLE);
        next_cycle(); settle();
        check_eq("raw_ack", cpu_rd_ack, 1);
        check_eq("raw_data", cpu_rd_data, 8'h3C);
        check_eq("raw_busy_ack", arb_state, S_IDLE);
        next_cycle(); cpu_rd_req = 1'b0; settle();
        check_eq("raw_ack_end", cpu_rd_ack, 0);

        // read blocked by same-cycle push, then read/video collision
        next_cycle(); drive_wr(15'h0210, 8'h55); cpu_rd_req = 1'b1; cpu_rd_addr = 15'h0200; settle();
        check_eq("push_blocks_rd", arb_state, S_IDLE);
        next_cycle(); cpu_wr_req = 1'b0; settle();
        check_eq("col_drain", arb_state, S_WDRAIN);
        next_cycle(); settle();
        check_eq("col_rd_grant", arb_state, S_RD);
        check_eq("col_rd_addr", mem_addr, 15'h0200);
        next_cycle(); drive_vid(15'h2000); settle();
        check_eq("col_vid_grant", arb_state, S_VID);
        check_eq("col_vid_addr", mem_addr, 15'h2000);
        next_cycle(); vid_req = 1'b0; settle();
        check_eq("col_ack", cpu_rd_ack, 1);
        check_eq("col_rd_data", cpu_rd_data, 8'h11);
        check_eq("col_vid_early", vid_valid, 0);
        check_eq("col_no_regrant", arb_state, S_IDLE);
        next_cycle(); cpu_rd_req = 1'b0; settle();
        check_eq("col_vid_valid", vid_valid, 1);
        check_eq("col_vid_data", vid_data, 8'h77);
        check_eq("col_ack_end", cpu_rd_ack, 0);

        // reset with 3 writes buffered and a video fetch in flight
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive_vid(15'h1800); drive_wr(15'h5000 + 15'(i), 8'hA0 + 8'(i));
        end
        next_cycle(); drive_idle(); reset = 1'b1; settle();
        check_eq("mid_rst_level", wbuf_level, 0);
        check_eq("mid_rst_ovf", wbuf_ovf, 0);
        check_eq("mid_rst_ready", cpu_wr_ready, 1);
        next_cycle();
        next_cycle(); reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_eq("post_rst_vid_valid", vid_valid, 0);
            check_eq("post_rst_we", mem_we, 0);
            check_eq("post_rst_level", wbuf_level, 0);
            next_cycle();
        end
        check_eq("post_rst_vram", vram[15'h5000], 8'h00);

        // reset one cycle after a read grant
        cpu_rd_req = 1'b1; cpu_rd_addr = 15'h0200; settle();
        check_eq("rst_rd_grant", arb_state, S_RD);
        next_cycle(); cpu_rd_req = 1'b0; reset = 1'b1; settle();
        check_eq("rst_rd_ack0", cpu_rd_ack, 0);
        next_cycle(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("post_rst_ack", cpu_rd_ack, 0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
